// File: rtl/m_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m_spi_arbiter
// Brief    : Two-requester SPI master controller. One mode-0 datapath
//            (8-bit, MSB first) is shared between requesters 0 and 1. Each
//            requester drives its own active-low slave select. The received
//            byte is returned together with the requester ID.
// Options  : SPI_ARB_RR_EN - round-robin arbitration. When it is undefined,
//            fixed priority is used and requester 0 wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module m_spi_arbiter #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic [1:0] SS
);

  localparam int               CNT_W     = 16;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SS_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             owner_q, owner_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [7:0]       rsp_data_q, rsp_data_d;

  logic             gnt0, gnt1;
  logic             idle, selected;

  assign idle     = (state_q == ST_IDLE);
  // The owner's select stays low through the shift phase and the trailing hold.
  assign selected = (state_q == ST_SHIFT) || (state_q == ST_HOLD);

`ifdef SPI_ARB_RR_EN
  // prio_q == 1 means requester 1 wins when both requesters are valid.
  logic prio_q, prio_d;

  // Arbitration winner: the pointer decides only when both requesters are valid.
  always_comb begin
    gnt1 = req1_valid & (~req0_valid | prio_q);
    gnt0 = req0_valid & ~gnt1;
  end

  // After a grant, hand priority to the other requester.
  always_comb begin
    prio_d = prio_q;
    if (req0_ready)      prio_d = 1'b1;
    else if (req1_ready) prio_d = 1'b0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
`else
  assign gnt0 = req0_valid;
  assign gnt1 = req1_valid & ~req0_valid;
`endif

  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;

  assign busy      = ~idle;
  assign SCLK      = sclk_q;
  assign MOSI      = selected & tx_q[7];
  assign SS        = selected ? (owner_q ? 2'b01 : 2'b10) : 2'b11;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

  // Next-state and datapath: the half-period counter paces SCLK, and its edges shift the data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    sclk_d      = sclk_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    owner_d     = owner_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = ST_SHIFT;
          owner_d = req1_ready;
          tx_d    = req1_ready ? req1_data : req0_data;
          cnt_d   = '0;
          edge_d  = 4'd0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 4'd1;
          if (!sclk_q) begin
            // Rising edge: sample MISO into the RX register, MSB first.
            rx_d = {rx_q[6:0], MISO};
          end else begin
            // Falling edge: present the next TX bit.
            tx_d = {tx_q[6:0], 1'b0};
            if (edge_q == 4'd15) state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d       = '0;
          state_d     = ST_GAP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_data_d  = rx_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. Reset drops any in-flight transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      edge_q      <= 4'd0;
      sclk_q      <= 1'b0;
      tx_q        <= 8'h00;
      rx_q        <= 8'h00;
      owner_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      sclk_q      <= sclk_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/m_spi_arbiter.md
# m_spi_arbiter

Master-side SPI transaction controller that shares one SPI master datapath between two requesters, each addressing its own slave-select line. It arbitrates requests, generates SCLK/SS/MOSI for 8-bit MSB-first transfers, captures MISO, and returns the received byte with the requester ID. It sits in the master FPGA between local logic and the SPI pins driving `s_spi_control` slaves.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; legal range ≥2.
- `SS_GAP`, 4: `clk` cycles with all SS high between transactions; legal range ≥1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a byte to send to slave 0.
- `req0_data`  in  8  byte for slave 0.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same for requester 1 and slave 1.
- `rsp_valid`  out  1  one-cycle pulse; received byte available.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_data`  out  8  byte captured from MISO.
- `busy`  out  1  high in any state other than IDLE.
- `SCLK`  out  1  SPI clock; idles low (mode 0).
- `MOSI`  out  1  master data out, MSB first.
- `MISO`  in  1  slave data in.
- `SS`  out  2  active-low selects; `SS[i]` belongs to requester i.

## Operation
- FSM: IDLE → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - `reqX_ready` is combinational: it is high only for the arbitration winner, and only when that requester's valid is high.
  - Acceptance happens when valid and ready are both high at a clk edge. On acceptance, latch the data into the TX shift register, record the owner, and go to SHIFT.
- Requesters hold valid and data stable until ready. Data is not sampled after acceptance.
- SHIFT:
  - `SS[owner]` is low. `MOSI` = TX[7].
  - 8 SCLK periods. Each rising edge shifts MISO into the RX register LSB, so the MSB is received first. Each falling edge shifts TX left.
  - After the 8th falling edge, go to HOLD.
- HOLD: SCLK low, SS still low for `CLK_DIV` cycles. Then SS goes high, `rsp_valid` pulses with `rsp_id`/`rsp_data`, and the FSM goes to GAP.
- GAP: all SS high for `SS_GAP` cycles. Then IDLE.
- There is no response backpressure. `rsp_data`/`rsp_id` hold their values until the next response.
- The non-owner SS line stays high throughout.
- `MOSI` = 0 whenever no SS is low.

## Timing
Accept edge = cycle 0, with H = `CLK_DIV`.
- `SS[owner]` low from cycle 1.
- SCLK rising edges at 1+H·(2k+1) and falling edges at 1+H·(2k+2), for k = 0..7.
- SS high and `rsp_valid` at cycle 1+17H.
- IDLE at 1+17H+`SS_GAP`; the earliest next accept is that cycle.
- Defaults: SS low at cycle 1, first SCLK rise at 5, last fall at 65, SS high and rsp at 69, next accept at 73.
- MISO is registered on the clk edge that drives SCLK high. The slave changes MISO on SCLK falling edges.
- Reset values: SCLK=0, MOSI=0, SS=2'b11, both ready=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, FSM=IDLE, round-robin pointer favours requester 0.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronously). No response is issued and the in-flight request is lost.
- Requests arriving while busy wait. Their valid stays high; no queueing beyond that.

## Configuration
- `SPI_ARB_RR_EN` defined: round-robin arbitration.
  - After granting requester i, the other requester has priority at the next arbitration.
  - With both valid continuously, grants alternate 0, 1, 0, 1, …
- `SPI_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins a simultaneous request, and the pointer logic is removed.

## Test plan
- Reset, then `req0_data`=8'hA5 while the slave model returns 8'h3C → `req0_ready` at cycle 0, `SS`=2'b10 for cycles 1–68, MOSI bits 1,0,1,0,0,1,0,1, `rsp_valid` at 69 with `rsp_id`=0 and `rsp_data`=8'h3C.
- `req1_data`=8'hFF with MISO tied 0 → only `SS[1]` toggles, `rsp_id`=1, `rsp_data`=8'h00, `SS[0]` never low.
- Both valid continuously, three transactions, with `SPI_ARB_RR_EN` → owners 0, 1, 0. Without the macro → owners 0, 0, 0.
- `req1_valid` raised at cycle 10 of a requester-0 transfer → `req1_ready` stays low until cycle 73, then is accepted. All SS high for cycles 69–72.
- Assert `rst` at cycle 30 mid-transfer → SCLK=0 and SS=2'b11 within the same cycle, no `rsp_valid`, a new request is accepted normally after release.
- `CLK_DIV`=2, `SS_GAP`=1, data 8'h81 → SCLK period 4 cycles, `rsp_valid` at cycle 35, idle again at 36.
